// File: rtl/msi_cache_ctrl.sv
// Direct-mapped private L1 data cache controller with MSI snooping.
// Optional MSI_STATS_EN adds saturating hit_count/miss_count outputs.
module msi_cache_ctrl #(
  parameter int LINES   = 4,
  parameter int INDEX_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic [11:0] cpu_tag,
  input  logic [15:0] cpu_data,
  output logic        cpu_done,
  output logic [15:0] cpu_rdata,
  output logic        bus_req,
  output logic [1:0]  bus_op,
  output logic [11:0] bus_tag,
  output logic [15:0] bus_data,
  input  logic        bus_grant,
  input  logic        mem_valid,
  input  logic [15:0] mem_data,
  input  logic        snoop_valid,
  input  logic [1:0]  snoop_op,
  input  logic [11:0] snoop_tag,
  output logic        snoop_flush,
  output logic [15:0] flush_data
`ifdef MSI_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10} line_st_e;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, MISS_REQ, UPG_REQ, WAIT_MEM, DONE} fsm_e;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_RDX = 2'b01;
  localparam logic [1:0] OP_UPG = 2'b10;
  localparam logic [1:0] OP_WB  = 2'b11;

  line_st_e    st_q  [LINES];
  logic [11:0] tag_q [LINES];
  logic [15:0] dat_q [LINES];

  fsm_e        fsm_q;
  logic        hold_q;
  logic        req_write_q;
  logic [11:0] req_tag_q;
  logic [15:0] req_data_q;
  logic        cpu_done_q;
  logic [15:0] cpu_rdata_q;
  logic        bus_req_q;
  logic [1:0]  bus_op_q;
  logic [11:0] bus_tag_q;
  logic [15:0] bus_data_q;

  logic [INDEX_W-1:0] req_idx;
  logic [INDEX_W-1:0] snp_idx;
  logic               req_hit;
  logic               snp_hit;
  logic               snp_upd;
  logic               snp_on_req;
  logic               flush;
  line_st_e           snp_st_d;

  assign req_idx    = req_tag_q[INDEX_W-1:0];
  assign snp_idx    = snoop_tag[INDEX_W-1:0];
  assign req_hit    = (st_q[req_idx] != ST_I) && (tag_q[req_idx] == req_tag_q);
  assign snp_hit    = snoop_valid && (st_q[snp_idx] != ST_I) && (tag_q[snp_idx] == snoop_tag);
  assign snp_upd    = snp_hit && (snp_st_d != st_q[snp_idx]);
  // A snoop that changes the line our request targets (or its victim) must redirect the FSM.
  assign snp_on_req = snp_upd && (snp_idx == req_idx);

  always_comb begin
    snp_st_d = st_q[snp_idx];
    flush    = 1'b0;
    if (snp_hit) begin
      case (snoop_op)
        OP_RD: begin
          if (st_q[snp_idx] == ST_M) begin
            snp_st_d = ST_S;
            flush    = 1'b1;
          end
        end
        OP_RDX: begin
          flush    = (st_q[snp_idx] == ST_M);
          snp_st_d = ST_I;
        end
        OP_UPG: begin
          if (st_q[snp_idx] == ST_S) snp_st_d = ST_I;
        end
        default: snp_st_d = st_q[snp_idx];
      endcase
    end
  end

  assign snoop_flush = flush;
  assign flush_data  = flush ? dat_q[snp_idx] : 16'h0000;

`ifdef MSI_STATS_EN
  logic        stat_hit_q;
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        st_q[i]  <= ST_I;
        tag_q[i] <= 12'h000;
        dat_q[i] <= 16'h0000;
      end
      fsm_q       <= IDLE;
      hold_q      <= 1'b0;
      req_write_q <= 1'b0;
      req_tag_q   <= 12'h000;
      req_data_q  <= 16'h0000;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= 16'h0000;
      bus_req_q   <= 1'b0;
      bus_op_q    <= OP_RD;
      bus_tag_q   <= 12'h000;
      bus_data_q  <= 16'h0000;
`ifdef MSI_STATS_EN
      stat_hit_q  <= 1'b0;
      hit_cnt_q   <= 16'h0000;
      miss_cnt_q  <= 16'h0000;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          if (hold_q) begin
            if (!(cpu_write || cpu_read)) hold_q <= 1'b0;
          end else if (cpu_write || cpu_read) begin
            req_write_q <= cpu_write;
            req_tag_q   <= cpu_tag;
            req_data_q  <= cpu_data;
            fsm_q       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!snp_on_req) begin
`ifdef MSI_STATS_EN
            stat_hit_q <= req_hit;
`endif
            if (req_hit && !req_write_q) begin
              cpu_done_q  <= 1'b1;
              cpu_rdata_q <= dat_q[req_idx];
              fsm_q       <= DONE;
            end else if (req_hit && st_q[req_idx] == ST_M) begin
              dat_q[req_idx] <= req_data_q;
              cpu_done_q     <= 1'b1;
              cpu_rdata_q    <= 16'h0000;
              fsm_q          <= DONE;
            end else if (req_hit) begin
              bus_req_q  <= 1'b1;
              bus_op_q   <= OP_UPG;
              bus_tag_q  <= req_tag_q;
              bus_data_q <= 16'h0000;
              fsm_q      <= UPG_REQ;
            end else if (st_q[req_idx] == ST_M) begin
              bus_req_q  <= 1'b1;
              bus_op_q   <= OP_WB;
              bus_tag_q  <= tag_q[req_idx];
              bus_data_q <= dat_q[req_idx];
              fsm_q      <= WB_REQ;
            end else begin
              bus_req_q  <= 1'b1;
              bus_op_q   <= req_write_q ? OP_RDX : OP_RD;
              bus_tag_q  <= req_tag_q;
              bus_data_q <= 16'h0000;
              fsm_q      <= MISS_REQ;
            end
          end
        end
        WB_REQ: begin
          // A snoop flush already delivered the victim data, so the WriteBack is dropped.
          if (snp_on_req || bus_grant) begin
            if (!snp_on_req) st_q[req_idx] <= ST_I;
            bus_req_q  <= 1'b1;
            bus_op_q   <= req_write_q ? OP_RDX : OP_RD;
            bus_tag_q  <= req_tag_q;
            bus_data_q <= 16'h0000;
            fsm_q      <= MISS_REQ;
          end
        end
        UPG_REQ: begin
          if (snp_on_req || !req_hit) begin
            bus_op_q <= OP_RDX;
            fsm_q    <= MISS_REQ;
          end else if (bus_grant) begin
            bus_req_q      <= 1'b0;
            bus_op_q       <= OP_RD;
            bus_tag_q      <= 12'h000;
            st_q[req_idx]  <= ST_M;
            dat_q[req_idx] <= req_data_q;
            cpu_done_q     <= 1'b1;
            cpu_rdata_q    <= 16'h0000;
            fsm_q          <= DONE;
          end
        end
        MISS_REQ: begin
          if (bus_grant) begin
            bus_req_q <= 1'b0;
            bus_op_q  <= OP_RD;
            bus_tag_q <= 12'h000;
            fsm_q     <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (mem_valid) begin
            tag_q[req_idx] <= req_tag_q;
            st_q[req_idx]  <= req_write_q ? ST_M : ST_S;
            dat_q[req_idx] <= req_write_q ? req_data_q : mem_data;
            cpu_done_q     <= 1'b1;
            cpu_rdata_q    <= req_write_q ? 16'h0000 : mem_data;
            fsm_q          <= DONE;
          end
        end
        DONE: begin
          cpu_done_q  <= 1'b0;
          cpu_rdata_q <= 16'h0000;
          hold_q      <= 1'b1;
          fsm_q       <= IDLE;
`ifdef MSI_STATS_EN
          if (stat_hit_q) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
          end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
          end
`endif
        end
        default: fsm_q <= IDLE;
      endcase
      // Snoop state change is applied last so it overrides any local update this cycle.
      if (snp_upd) st_q[snp_idx] <= snp_st_d;
    end
  end

  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_op    = bus_op_q;
  assign bus_tag   = bus_tag_q;
  assign bus_data  = bus_data_q;

endmodule

// File: doc/msi_cache_ctrl.md
Name: msi_cache_ctrl

Overview:
- Private direct-mapped L1 data cache controller with MSI snooping; one instance per processor.
- Sits directly downstream of the CPU request stage and consumes its write/read/tag/data request.
- Issues bus transactions toward shared memory.
- Snoops the shared bus and supplies flush data from Modified lines.

Parameters:
LINES, 4, number of cache lines (power of 2)
INDEX_W, 2, log2(LINES); index = cpu_tag[INDEX_W-1:0]; full 12-bit tag stored per line

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cpu_write  in  1  write request from CPU stage (level, held until cpu_done)
cpu_read  in  1  read request from CPU stage (level, held until cpu_done)
cpu_tag  in  12  request address/tag
cpu_data  in  16  write data
cpu_done  out  1  one-cycle pulse, request completed
cpu_rdata  out  16  read data, valid with cpu_done
bus_req  out  1  bus transaction request, held until bus_grant
bus_op  out  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 WriteBack
bus_tag  out  12  transaction tag
bus_data  out  16  WriteBack data
bus_grant  in  1  arbiter grant, one cycle
mem_valid  in  1  fill data valid
mem_data  in  16  fill data
snoop_valid  in  1  another cache's transaction on the bus
snoop_op  in  2  same encoding as bus_op
snoop_tag  in  12  snooped tag
snoop_flush  out  1  this cache supplies data (was M)
flush_data  out  16  flushed line data

Behaviour:
- Line state: 2 bits per line (I=00, S=01, M=10), plus 12-bit tag and 16-bit data.
- Reset: all lines I; all outputs 0; FSM in IDLE.
- FSM states: IDLE, LOOKUP, WB_REQ, MISS_REQ, UPG_REQ, WAIT_MEM, DONE.
- Request capture:
  - IDLE: cpu_write|cpu_read captures tag/data/op and goes to LOOKUP.
  - Both high: treated as write.
- LOOKUP, read hit (S/M): DONE next cycle. Total latency request->cpu_done = 2 cycles.
- LOOKUP, write hit M: update data, then DONE.
- LOOKUP, write hit S: go to UPG_REQ. bus_req=1, op=10. On grant: line->M, write data, DONE.
- LOOKUP, miss with victim M: go to WB_REQ. op=11 with victim tag/data. On grant: victim->I, then MISS_REQ.
- LOOKUP, miss with victim I/S: go directly to MISS_REQ.
- MISS_REQ:
  - Read: op=00. Write: op=01.
  - On grant, go to WAIT_MEM.
  - mem_valid: read installs S with mem_data; write installs M with cpu_data (write-allocate, fill discarded). Then DONE.
- DONE: cpu_done=1 for one cycle; cpu_rdata = line data for reads, 0 for writes; return to IDLE.
- IDLE hold rule: IDLE requires one cycle with no request seen after DONE before capturing again. This prevents double-issue of a held level request.
- bus_req, bus_op and bus_tag stay stable from assertion until the grant cycle inclusive.
- Snoop handling:
  - Evaluated every cycle in any FSM state.
  - Hit = line valid and stored tag == snoop_tag.
  - BusRd on M: snoop_flush=1 and flush_data=line data the same cycle (combinational); line->S.
  - BusRdX on M: flush, ->I.
  - BusRdX/BusUpgr on S: ->I.
  - WriteBack op: ignored. Misses: ignored.
- Simultaneous events:
  - Snoop state update wins over a local update in the same cycle.
  - In UPG_REQ, a snoop invalidating the target line switches the request to op=01 and continues as a write miss via WAIT_MEM.
  - Snoop hit on the WB_REQ victim M line with BusRd/BusRdX: flush, victim state updated, WriteBack dropped, go to MISS_REQ.
- Reset mid-operation: abort the transaction, deassert bus_req next edge, invalidate all lines.

Optional Feature:
- MSI_STATS_EN defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments once per completed request (at DONE).
  - Saturating at 16'hFFFF; cleared by reset.
  - Write hit on S counts as a hit.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Read 12'h005 cold -> op=00 tag 005; grant; mem_data 16'hBEEF -> cpu_done, cpu_rdata BEEF, line1 S.
- Write 12'h005 data 16'h1234 while S -> op=10; grant -> done, line M; re-read returns 1234 in 2 cycles, no bus_req.
- Line 005 M, snoop BusRd 005 -> snoop_flush=1, flush_data 1234 same cycle, line->S; snoop BusRdX 005 -> line I, no flush.
- Line 005 M, read 12'h009 (same index) -> op=11 tag 005 data 1234, then op=00 tag 009.
- In UPG_REQ for 005 (S), snoop BusUpgr 005 before grant -> bus_op changes 10->01; on mem_valid, line M with cpu_data.
- Reset asserted in WAIT_MEM -> next edge: bus_req=0, cpu_done=0, all lines I; subsequent read of 005 misses.
